// File: rtl/pc_reg_unit.sv
// Program-counter register with stall, redirect (one-cycle flush bubble),
// sticky misalignment flag and a terminal halt state.
module pc_reg_unit #(
  parameter int               WIDTH    = 16,
  parameter int               INCR     = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             fetch_valid,
  output logic             halted,
  output logic             misalign_err
);

  // INCR is a power of two, so INCR-1 covers exactly the low alignment bits;
  // for INCR=1 the mask is zero and nothing is cleared or flagged.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INCR - 1);
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(INCR);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic             target_misaligned;

  assign pc_plus           = pc + STEP;
  assign target            = redirect_pc & ~ALIGN_MASK;
  assign target_misaligned = |(redirect_pc & ALIGN_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      state        <= RUN;
      fetch_valid  <= 1'b1;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        RUN, BUBBLE: begin
          if (redirect_valid) begin
            pc          <= target;
            state       <= BUBBLE;
            fetch_valid <= 1'b0;
            if (target_misaligned)
              misalign_err <= 1'b1;
          end else if (halt) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end else if (!stall) begin
            // A bubble already holds the target, so it only returns to RUN.
            if (state == RUN) begin
              pc <= pc_plus;
            end else begin
              state       <= RUN;
              fetch_valid <= 1'b1;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state       <= HALT;
          fetch_valid <= 1'b0;
          halted      <= 1'b1;
        end
      endcase
    end
  end

endmodule
